// File: rtl/svn_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-digit pattern registers,
// round-robin digit select with leading dead time and PWM brightness.
module svn_seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEAD     = 2,
    parameter int PWM_BITS = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic [$clog2(DIGITS)-1:0]   wr_addr_i,
    input  logic [7:0]                  wr_data_i,
    input  logic [PWM_BITS-1:0]         bright_i,
    input  logic                        blank_i,
    output logic [7:0]                  display_o,
    output logic [DIGITS-1:0]           seg_sel_o,
    output logic                        frame_o
);

    localparam int AW = $clog2(DIGITS);
    localparam int SW = $clog2(SCAN_DIV);

    localparam logic [SW-1:0]     S_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]     DEAD_S  = SW'(DEAD);
    localparam logic [AW-1:0]     D_LAST  = AW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

    logic [SW-1:0]       s_reg;
    logic [AW-1:0]       d_reg;
    logic [PWM_BITS-1:0] p_reg;
    logic [7:0]          pat_reg [DIGITS];

    logic [DIGITS-1:0]   wr_hit;
    logic                lit_next;
    logic [DIGITS-1:0]   sel_next;
    logic [7:0]          disp_next;
    logic                frame_next;

    logic [7:0]          display_reg;
    logic [DIGITS-1:0]   seg_sel_reg;
    logic                frame_reg;

    // Out-of-range addresses match no decode line, so they are silently dropped.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_wr_dec
            assign wr_hit[gi] = wr_en_i && (wr_addr_i == AW'(gi));
        end
    endgenerate

    always_comb begin
        lit_next   = (s_reg >= DEAD_S) && (p_reg < bright_i) && !blank_i;
        sel_next   = '0;
        disp_next  = '0;
        frame_next = (s_reg == '0) && (d_reg == '0);
        if (lit_next) begin
            sel_next  = SEL_ONE << d_reg;
            disp_next = pat_reg[d_reg];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_reg       <= '0;
            d_reg       <= '0;
            p_reg       <= '0;
            display_reg <= '0;
            seg_sel_reg <= '0;
            frame_reg   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                pat_reg[i] <= '0;
            end
        end else begin
            p_reg <= p_reg + 1'b1;
            if (s_reg == S_LAST) begin
                s_reg <= '0;
                d_reg <= (d_reg == D_LAST) ? '0 : d_reg + 1'b1;
            end else begin
                s_reg <= s_reg + 1'b1;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (wr_hit[i]) begin
                    pat_reg[i] <= wr_data_i;
                end
            end
            // Output regs sample the pattern file after any earlier write has landed.
            display_reg <= disp_next;
            seg_sel_reg <= sel_next;
            frame_reg   <= frame_next;
        end
    end

    assign display_o = display_reg;
    assign seg_sel_o = seg_sel_reg;
    assign frame_o   = frame_reg;

endmodule

// File: tb/tb_svn_seg_scan_ctrl.sv
// Scoreboard bench for svn_seg_scan_ctrl: a 4-digit instance and a 3-digit
// instance share the write bus so digit-3 writes are out of range for the latter.
module tb_svn_seg_scan_ctrl;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] disp;
        logic       frame;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] bright;
    logic       blank;

    logic [7:0] disp_a;
    logic [3:0] sel_a;
    logic       frame_a;
    logic [7:0] disp_b;
    logic [2:0] sel_b;
    logic       frame_b;

    exp_t        exp_a_q[$];
    exp_t        exp_b_q[$];
    int          n_checks;
    int          n_fail;
    int unsigned m_t;
    logic [7:0]  m_pat_a [4];
    logic [7:0]  m_pat_b [3];
    int          lit_cnt;
    int unsigned cyc_a;
    int unsigned cyc_b;
    int unsigned last_frame;
    logic        frame_ref_valid;
    int          c0;
    int          c1;

    svn_seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .PWM_BITS(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .bright_i(bright), .blank_i(blank),
        .display_o(disp_a), .seg_sel_o(sel_a), .frame_o(frame_a)
    );

    svn_seg_scan_ctrl #(.DIGITS(3), .SCAN_DIV(4), .DEAD(1), .PWM_BITS(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .bright_i(2'd3), .blank_i(blank),
        .display_o(disp_b), .seg_sel_o(sel_b), .frame_o(frame_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_model();
        m_t = 0;
        for (int i = 0; i < 4; i++) m_pat_a[i] = 8'h00;
        for (int i = 0; i < 3; i++) m_pat_b[i] = 8'h00;
    endtask

    // Drive one cycle of inputs and push what each DUT must show after the next edge.
    task automatic step(input logic r, input logic we, input logic [1:0] a,
                        input logic [7:0] dat, input logic [3:0] br, input logic bl);
        exp_t ea;
        exp_t eb;
        int unsigned s;
        int unsigned d;
        int unsigned p;
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = a; wr_data = dat; bright = br; blank = bl;
        ea = '0;
        eb = '0;
        if (!r) begin
            s = m_t % 8; d = (m_t / 8) % 4; p = m_t % 16;
            ea.frame = (m_t % 32 == 0);
            if (s >= 2 && p < br && !bl) begin
                ea.sel  = 4'(1 << d);
                ea.disp = m_pat_a[d];
            end
            s = m_t % 4; d = (m_t / 4) % 3; p = m_t % 4;
            eb.frame = (m_t % 12 == 0);
            if (s >= 1 && p < 3 && !bl) begin
                eb.sel  = 4'(1 << d);
                eb.disp = m_pat_b[d];
            end
            if (we) begin
                m_pat_a[a] = dat;
                if (a < 2'd3) m_pat_b[a] = dat;
            end
            m_t++;
        end else begin
            clear_model();
        end
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
    endtask

    task automatic idle(input int n, input logic [3:0] br, input logic bl);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'h00, br, bl);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor for the 4-digit instance; also tracks frame spacing and lit cycles.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #2;
            cyc_a++;
            if (sel_a != 4'b0) lit_cnt++;
            if (frame_a) begin
                if (frame_ref_valid) check_int("frame_period", int'(cyc_a - last_frame), 32);
                last_frame      = cyc_a;
                frame_ref_valid = 1'b1;
            end
            if (exp_a_q.size() > 0) begin
                e   = exp_a_q.pop_front();
                act = '{sel: sel_a, disp: disp_a, frame: frame_a};
                n_checks++;
                if (act != e) begin
                    n_fail++;
                    $display("FAIL sb_a cyc=%0d sel=%b req %b disp=%h req %h frame=%b req %b",
                             cyc_a, act.sel, e.sel, act.disp, e.disp, act.frame, e.frame);
                end else begin
                    $display("sb_a cyc=%0d sel=%b disp=%h frame=%b ok", cyc_a, act.sel, act.disp, act.frame);
                end
            end
        end
    end

    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #2;
            cyc_b++;
            if (exp_b_q.size() > 0) begin
                e   = exp_b_q.pop_front();
                act = '{sel: {1'b0, sel_b}, disp: disp_b, frame: frame_b};
                n_checks++;
                if (act != e) begin
                    n_fail++;
                    $display("FAIL sb_b cyc=%0d sel=%b req %b disp=%h req %h frame=%b req %b",
                             cyc_b, act.sel, e.sel, act.disp, e.disp, act.frame, e.frame);
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0; lit_cnt = 0; cyc_a = 0; cyc_b = 0;
        last_frame = 0; frame_ref_valid = 1'b0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; bright = 4'd15; blank = 1'b0;
        clear_model();

        repeat (5) step(1'b1, 1'b0, 2'd0, 8'h00, 4'd15, 1'b0);

        // All digits lit 0xFF at full brightness (t = 0..31).
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 8'hFF, 4'd15, 1'b0);
        idle(28, 4'd15, 1'b0);
        // Window t = 32..63: 24 ON cycles minus p==15 at t=47 and t=63.
        idle(1, 4'd15, 1'b0);
        c0 = lit_cnt;
        idle(32, 4'd15, 1'b0);
        c1 = lit_cnt;
        check_int("lit_max_bright", c1 - c0, 22);

        // Digit patterns 0..3 (digit 3 is out of range for the 3-digit instance).
        step(1'b0, 1'b1, 2'd0, 8'h3F, 4'd15, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h06, 4'd15, 1'b0);
        step(1'b0, 1'b1, 2'd2, 8'h5B, 4'd15, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'h4F, 4'd15, 1'b0);
        idle(47, 4'd15, 1'b0);
        // Live write while digit 2 is on screen (t = 116, slot 2, s = 4).
        step(1'b0, 1'b1, 2'd2, 8'h80, 4'd15, 1'b0);
        idle(11, 4'd15, 1'b0);

        // bright=4 over t = 128..159: lit only at t = 130,131,146,147.
        idle(1, 4'd4, 1'b0);
        c0 = lit_cnt;
        idle(31, 4'd4, 1'b0);
        idle(1, 4'd0, 1'b0);
        c1 = lit_cnt;
        check_int("lit_bright4", c1 - c0, 4);

        // bright=0 over t = 160..191: never lit.
        c0 = lit_cnt;
        idle(31, 4'd0, 1'b0);
        idle(1, 4'd15, 1'b0);
        c1 = lit_cnt;
        check_int("lit_bright0", c1 - c0, 0);

        // Blank for three ON cycles of digit 0 (t = 196..198).
        idle(3, 4'd15, 1'b0);
        idle(3, 4'd15, 1'b1);
        idle(22, 4'd15, 1'b0);

        // Asynchronous reset between edges while digit 3 is lit (t = 220).
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_int("async_rst_sel_a", int'(sel_a), 0);
        check_int("async_rst_disp_a", int'(disp_a), 0);
        check_int("async_rst_frame_a", int'(frame_a), 0);
        check_int("async_rst_sel_b", int'(sel_b), 0);
        frame_ref_valid = 1'b0;
        rst = 1'b0;
        clear_model();

        idle(40, 4'd15, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
